// File: rtl/fwd_pipe.sv
// fwd_pipe: write-back pipeline from EX to the regfile write port.
// Carries {wreg, wd, wdata} through DEPTH register stages with per-stage
// stall/bubble insertion, a synchronous flush, and an NREAD-port
// youngest-first forwarding network that lets ID bypass in-flight results.
module fwd_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int NREAD  = 2,
  parameter int FWD_IN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_wreg,
  input  logic [ADDR_W-1:0]        in_wd,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic [DEPTH-1:0]         stall_i,
  input  logic                     flush_i,
  input  logic [NREAD*ADDR_W-1:0]  raddr_i,
  output logic [NREAD-1:0]         fwd_hit_o,
  output logic [NREAD*DATA_W-1:0]  fwd_data_o,
  output logic                     wb_wreg,
  output logic [ADDR_W-1:0]        wb_wd,
  output logic [DATA_W-1:0]        wb_wdata,
  output logic                     busy_o
);

  logic [DEPTH-1:0]  wreg_q, wreg_d;
  logic [ADDR_W-1:0] wd_q    [DEPTH];
  logic [ADDR_W-1:0] wd_d    [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] wdata_d [DEPTH];

  // Source of each stage: the EX bus for stage 0, otherwise the previous stage.
  logic [DEPTH-1:0]  src_wreg;
  logic [ADDR_W-1:0] src_wd    [DEPTH];
  logic [DATA_W-1:0] src_wdata [DEPTH];

  // stall_up[k] = stall_i[k-1]; zero for stage 0 (no upstream stage to starve it).
  logic [DEPTH-1:0]  stall_up;
  assign stall_up = stall_i << 1;

  for (genvar k = 0; k < DEPTH; k++) begin : g_src
    if (k == 0) begin : g_first
      assign src_wreg[k]  = in_wreg;
      assign src_wd[k]    = in_wd;
      assign src_wdata[k] = in_wdata;
    end else begin : g_chain
      assign src_wreg[k]  = wreg_q[k-1];
      assign src_wd[k]    = wd_q[k-1];
      assign src_wdata[k] = wdata_q[k-1];
    end
  end

  // Next-stage selection: flush beats stall; a stalled stage holds, a stage
  // whose upstream neighbour is stalled takes a bubble, otherwise it advances.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      wreg_d[k]  = wreg_q[k];
      wd_d[k]    = wd_q[k];
      wdata_d[k] = wdata_q[k];
      if (flush_i || (!stall_i[k] && stall_up[k])) begin
        wreg_d[k]  = 1'b0;
        wd_d[k]    = '0;
        wdata_d[k] = '0;
      end else if (!stall_i[k]) begin
        wreg_d[k]  = src_wreg[k];
        wd_d[k]    = src_wd[k];
        wdata_d[k] = src_wdata[k];
      end
    end
  end

  // Stage registers; reset empties the whole pipe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wd_q[k]    <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      wreg_q <= wreg_d;
      for (int k = 0; k < DEPTH; k++) begin
        wd_q[k]    <= wd_d[k];
        wdata_q[k] <= wdata_d[k];
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overwrites.
  // The EX bus is masked while in reset so all outputs read zero then.
  always_comb begin
    fwd_hit_o  = '0;
    fwd_data_o = '0;
    for (int p = 0; p < NREAD; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (wreg_q[k] && (wd_q[k] == raddr_i[p*ADDR_W +: ADDR_W]) && (wd_q[k] != '0)) begin
          fwd_hit_o[p]                   = 1'b1;
          fwd_data_o[p*DATA_W +: DATA_W] = wdata_q[k];
        end
      end
      if ((FWD_IN != 0) && rst && in_wreg &&
          (in_wd == raddr_i[p*ADDR_W +: ADDR_W]) && (in_wd != '0)) begin
        fwd_hit_o[p]                   = 1'b1;
        fwd_data_o[p*DATA_W +: DATA_W] = in_wdata;
      end
    end
  end

  assign wb_wreg  = wreg_q[DEPTH-1];
  assign wb_wd    = wd_q[DEPTH-1];
  assign wb_wdata = wdata_q[DEPTH-1];
  assign busy_o   = |wreg_q;

endmodule

// File: tb/tb_fwd_pipe.sv
// Testbench for fwd_pipe: a DEPTH=3/NREAD=2 instance driven through a
// scoreboard queue of stage contents, plus a DEPTH=1/NREAD=3 instance.
module tb_fwd_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 3;
  localparam int NR = 2;
  localparam int NR1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic            in_wreg;
  logic [AW-1:0]   in_wd;
  logic [DW-1:0]   in_wdata;
  logic [D-1:0]    stall;
  logic            flush;
  logic [NR*AW-1:0] raddr;
  logic [NR-1:0]   fwd_hit;
  logic [NR*DW-1:0] fwd_data;
  logic            wb_wreg;
  logic [AW-1:0]   wb_wd;
  logic [DW-1:0]   wb_wdata;
  logic            busy;

  // depth-1 instance
  logic             in_wreg1;
  logic [AW-1:0]    in_wd1;
  logic [DW-1:0]    in_wdata1;
  logic [0:0]       stall1;
  logic             flush1;
  logic [NR1*AW-1:0] raddr1;
  logic [NR1-1:0]   fwd_hit1;
  logic [NR1*DW-1:0] fwd_data1;
  logic             wb_wreg1;
  logic [AW-1:0]    wb_wd1;
  logic [DW-1:0]    wb_wdata1;
  logic             busy1;

  fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NREAD(NR), .FWD_IN(1)) dut (
    .clk(clk), .rst(rst), .in_wreg(in_wreg), .in_wd(in_wd), .in_wdata(in_wdata),
    .stall_i(stall), .flush_i(flush), .raddr_i(raddr),
    .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata), .busy_o(busy)
  );

  fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1), .NREAD(NR1), .FWD_IN(1)) dut1 (
    .clk(clk), .rst(rst), .in_wreg(in_wreg1), .in_wd(in_wd1), .in_wdata(in_wdata1),
    .stall_i(stall1), .flush_i(flush1), .raddr_i(raddr1),
    .fwd_hit_o(fwd_hit1), .fwd_data_o(fwd_data1),
    .wb_wreg(wb_wreg1), .wb_wd(wb_wd1), .wb_wdata(wb_wdata1), .busy_o(busy1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Expected stage contents of the main instance: sb[0] = stage D-1 (oldest),
  // sb[D-1] = stage 0 (youngest).
  ent_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_init();
    sb.delete();
    repeat (D) sb.push_back('0);
  endtask

  task automatic check_fwd_model(input string tag);
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] ra;
      logic          eh;
      logic [DW-1:0] ed;
      ra = raddr[p*AW +: AW];
      eh = 1'b0;
      ed = '0;
      if (in_wreg && in_wd == ra && ra != 0) begin
        eh = 1'b1;
        ed = in_wdata;
      end
      for (int k = D - 1; k >= 0; k--) begin
        if (!eh && sb[k].w && sb[k].a == ra && ra != 0) begin
          eh = 1'b1;
          ed = sb[k].d;
        end
      end
      checks++;
      if (fwd_hit[p] !== eh || fwd_data[p*DW +: DW] !== ed) begin
        errors++;
        $display("FAIL %s fwd port%0d: got hit=%0b data=%h, want hit=%0b data=%h",
                 tag, p, fwd_hit[p], fwd_data[p*DW +: DW], eh, ed);
      end
    end
  endtask

  // Drive one unstalled cycle, checking forwarding before the edge and
  // write-back/busy after it against the scoreboard.
  task automatic sb_cycle(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input string tag);
    ent_t exp;
    logic eb;
    in_wreg = w; in_wd = a; in_wdata = d; stall = '0; flush = 1'b0;
    #1;
    check_fwd_model(tag);
    sb.push_back({w, a, d});
    tick();
    void'(sb.pop_front());
    exp = sb[0];
    eb = 1'b0;
    for (int k = 0; k < D; k++) eb |= sb[k].w;
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== exp) begin
      errors++;
      $display("FAIL %s wb: got %0b/%0d/%h, want %0b/%0d/%h", tag,
               wb_wreg, wb_wd, wb_wdata, exp.w, exp.a, exp.d);
    end
    checks++;
    if (busy !== eb) begin
      errors++;
      $display("FAIL %s busy: got %0b, want %0b", tag, busy, eb);
    end
  endtask

  task automatic do_flush();
    in_wreg = 1'b0; in_wd = '0; in_wdata = '0; stall = '0; flush = 1'b1;
    tick();
    flush = 1'b0;
    sb_init();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_wreg = 1'b1; in_wd = 5'd5; in_wdata = 32'h55; stall = '0; flush = 1'b0;
    raddr = {5'd5, 5'd5};
    in_wreg1 = 1'b1; in_wd1 = 5'd5; in_wdata1 = 32'h55; stall1 = '0; flush1 = 1'b0;
    raddr1 = {5'd5, 5'd5, 5'd5};
    #2;
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset wb/busy: got %0b/%0d/%h/%0b, want 0", wb_wreg, wb_wd, wb_wdata, busy);
    end
    checks++;
    if (fwd_hit !== '0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL reset fwd: got hit=%b data=%h, want 0", fwd_hit, fwd_data);
    end
    checks++;
    if ({wb_wreg1, wb_wd1, wb_wdata1, busy1, fwd_hit1} !== '0 || fwd_data1 !== '0) begin
      errors++;
      $display("FAIL reset d1: got wb=%0b/%0d/%h busy=%0b hit=%b, want 0",
               wb_wreg1, wb_wd1, wb_wdata1, busy1, fwd_hit1);
    end
    in_wreg = 1'b0; in_wd = '0; in_wdata = '0; raddr = '0;
    in_wreg1 = 1'b0; in_wd1 = '0; in_wdata1 = '0; raddr1 = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    sb_init();
  endtask

  task automatic test_latency();
    raddr = {5'd0, 5'd5};
    sb_cycle(1'b1, 5'd5, 32'h11, "latency");
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) sb_cycle(1'b0, '0, '0, "latency");
      else begin
        in_wreg = 1'b0; in_wd = '0; in_wdata = '0;
      end
      // i counts edges after the one that captured the entry
      if (i < 4) begin
        if (i > 1) ; // already advanced by sb_cycle
      end
    end
    // directed: entry must be at wb exactly 3 edges after capture
    do_flush();
    in_wreg = 1'b1; in_wd = 5'd5; in_wdata = 32'h11;
    tick();
    in_wreg = 1'b0; in_wd = '0; in_wdata = '0;
    for (int i = 1; i <= 4; i++) begin
      logic ew;
      ew = (i == 3);
      checks++;
      if (wb_wreg !== ew || (ew && (wb_wd !== 5'd5 || wb_wdata !== 32'h11))) begin
        errors++;
        $display("FAIL latency edge%0d: got %0b/%0d/%h, want wreg=%0b", i, wb_wreg, wb_wd, wb_wdata, ew);
      end
      tick();
    end
    do_flush();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      raddr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      sb_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, "b2b");
    end
    do_flush();
  endtask

  task automatic test_priority();
    raddr = {5'd7, 5'd7};
    sb_cycle(1'b1, 5'd7, 32'hA, "prio");
    sb_cycle(1'b1, 5'd7, 32'hB, "prio");
    in_wreg = 1'b1; in_wd = 5'd7; in_wdata = 32'hC;
    #1;
    checks++;
    if (fwd_hit !== 2'b11 || fwd_data !== {32'hC, 32'hC}) begin
      errors++;
      $display("FAIL prio input: got hit=%b data=%h, want 11 / C,C", fwd_hit, fwd_data);
    end
    in_wreg = 1'b0;
    #1;
    checks++;
    if (fwd_hit[0] !== 1'b1 || fwd_data[31:0] !== 32'hB) begin
      errors++;
      $display("FAIL prio stage0: got hit=%0b data=%h, want 1/B", fwd_hit[0], fwd_data[31:0]);
    end
    in_wd = '0; in_wdata = '0;
    stall = 3'b110;
    tick();
    stall = '0;
    checks++;
    if (fwd_hit[0] !== 1'b1 || fwd_data[31:0] !== 32'hA || fwd_data[63:32] !== 32'hA) begin
      errors++;
      $display("FAIL prio stage1: got hit=%0b data=%h, want 1/A,A", fwd_hit[0], fwd_data);
    end
    do_flush();
  endtask

  task automatic test_r0();
    raddr = '0;
    sb_cycle(1'b1, 5'd0, 32'hFF, "r0");
    in_wreg = 1'b0;
    #1;
    checks++;
    if (fwd_hit !== '0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL r0 fwd: got hit=%b data=%h, want 0", fwd_hit, fwd_data);
    end
    sb_cycle(1'b0, '0, '0, "r0");
    sb_cycle(1'b0, '0, '0, "r0");
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd0, 32'hFF}) begin
      errors++;
      $display("FAIL r0 wb: got %0b/%0d/%h, want 1/0/ff", wb_wreg, wb_wd, wb_wdata);
    end
    do_flush();
  endtask

  task automatic test_stall();
    raddr = {5'd0, 5'd3};
    sb_cycle(1'b1, 5'd4, 32'h40, "stall");
    sb_cycle(1'b1, 5'd3, 32'h30, "stall");
    in_wreg = 1'b0; in_wd = '0; in_wdata = '0;
    stall = 3'b001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({wb_wreg, wb_wd, wb_wdata} !== ((i == 0) ? {1'b1, 5'd4, 32'h40} : 38'd0)) begin
        errors++;
        $display("FAIL stall wb cyc%0d: got %0b/%0d/%h", i, wb_wreg, wb_wd, wb_wdata);
      end
      checks++;
      if (fwd_hit[0] !== 1'b1 || fwd_data[31:0] !== 32'h30 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall hold cyc%0d: got hit=%0b data=%h busy=%0b, want 1/30/1",
                 i, fwd_hit[0], fwd_data[31:0], busy);
      end
    end
    stall = '0;
    tick();
    checks++;
    if (wb_wreg !== 1'b0) begin
      errors++;
      $display("FAIL stall release1: got wb_wreg=%0b, want 0", wb_wreg);
    end
    tick();
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd3, 32'h30}) begin
      errors++;
      $display("FAIL stall release2: got %0b/%0d/%h, want 1/3/30", wb_wreg, wb_wd, wb_wdata);
    end
    stall = 3'b111;
    tick();
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata} !== {1'b1, 5'd3, 32'h30}) begin
      errors++;
      $display("FAIL stall wb hold: got %0b/%0d/%h, want 1/3/30", wb_wreg, wb_wd, wb_wdata);
    end
    stall = '0;
    tick();
    checks++;
    if (wb_wreg !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall drain: got wb_wreg=%0b busy=%0b, want 0/0", wb_wreg, busy);
    end
    do_flush();
  endtask

  task automatic test_flush();
    raddr = {5'd3, 5'd1};
    sb_cycle(1'b1, 5'd1, 32'h1, "flush");
    sb_cycle(1'b1, 5'd2, 32'h2, "flush");
    sb_cycle(1'b1, 5'd3, 32'h3, "flush");
    flush = 1'b1; stall = 3'b111;
    in_wreg = 1'b1; in_wd = 5'd6; in_wdata = 32'h66;
    tick();
    flush = 1'b0; stall = '0;
    in_wreg = 1'b0; in_wd = '0; in_wdata = '0;
    #1;
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL flush wb/busy: got %0b/%0d/%h/%0b, want 0", wb_wreg, wb_wd, wb_wdata, busy);
    end
    checks++;
    if (fwd_hit !== '0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL flush fwd: got hit=%b data=%h, want 0", fwd_hit, fwd_data);
    end
    sb_init();
  endtask

  task automatic test_depth1();
    raddr1 = {5'd0, 5'd5, 5'd5};
    in_wreg1 = 1'b1; in_wd1 = 5'd5; in_wdata1 = 32'h11; stall1 = '0; flush1 = 1'b0;
    #1;
    checks++;
    if (fwd_hit1 !== 3'b011 || fwd_data1 !== {32'h0, 32'h11, 32'h11}) begin
      errors++;
      $display("FAIL d1 input fwd: got hit=%b data=%h, want 011", fwd_hit1, fwd_data1);
    end
    tick();
    in_wreg1 = 1'b0; in_wd1 = '0; in_wdata1 = '0;
    #1;
    checks++;
    if ({wb_wreg1, wb_wd1, wb_wdata1, busy1} !== {1'b1, 5'd5, 32'h11, 1'b1} ||
        fwd_hit1 !== 3'b011 || fwd_data1[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL d1 latency: got wb=%0b/%0d/%h busy=%0b hit=%b", wb_wreg1, wb_wd1, wb_wdata1, busy1, fwd_hit1);
    end
    stall1 = 1'b1;
    in_wreg1 = 1'b1; in_wd1 = 5'd6; in_wdata1 = 32'h22;
    tick();
    raddr1 = {5'd6, 5'd5, 5'd5};
    #1;
    checks++;
    if ({wb_wreg1, wb_wd1, wb_wdata1} !== {1'b1, 5'd5, 32'h11} || fwd_hit1 !== 3'b111 ||
        fwd_data1 !== {32'h22, 32'h11, 32'h11}) begin
      errors++;
      $display("FAIL d1 stall: got wb=%0b/%0d/%h hit=%b data=%h", wb_wreg1, wb_wd1, wb_wdata1, fwd_hit1, fwd_data1);
    end
    stall1 = 1'b0;
    tick();
    in_wdata1 = 32'h33;
    #1;
    checks++;
    if ({wb_wreg1, wb_wd1, wb_wdata1} !== {1'b1, 5'd6, 32'h22} || fwd_data1[95:64] !== 32'h33) begin
      errors++;
      $display("FAIL d1 advance: got wb=%0b/%0d/%h port2=%h, want 1/6/22 and 33",
               wb_wreg1, wb_wd1, wb_wdata1, fwd_data1[95:64]);
    end
    flush1 = 1'b1; stall1 = 1'b1;
    in_wreg1 = 1'b1; in_wd1 = 5'd7; in_wdata1 = 32'h77;
    tick();
    flush1 = 1'b0; stall1 = 1'b0;
    in_wreg1 = 1'b0; in_wd1 = '0; in_wdata1 = '0;
    #1;
    checks++;
    if ({wb_wreg1, wb_wd1, wb_wdata1, busy1, fwd_hit1} !== '0) begin
      errors++;
      $display("FAIL d1 flush: got wb=%0b/%0d/%h busy=%0b hit=%b", wb_wreg1, wb_wd1, wb_wdata1, busy1, fwd_hit1);
    end
    raddr1 = '0;
    in_wreg1 = 1'b1; in_wd1 = 5'd0; in_wdata1 = 32'hFF;
    tick();
    in_wreg1 = 1'b0; in_wdata1 = '0;
    #1;
    checks++;
    if ({wb_wreg1, wb_wd1, wb_wdata1} !== {1'b1, 5'd0, 32'hFF} || fwd_hit1 !== '0 || fwd_data1 !== '0) begin
      errors++;
      $display("FAIL d1 r0: got wb=%0b/%0d/%h hit=%b", wb_wreg1, wb_wd1, wb_wdata1, fwd_hit1);
    end
    tick();
  endtask

  task automatic test_async_reset();
    raddr = {5'd2, 5'd1};
    sb_cycle(1'b1, 5'd1, 32'h1, "arst");
    sb_cycle(1'b1, 5'd2, 32'h2, "arst");
    sb_cycle(1'b1, 5'd3, 32'h3, "arst");
    in_wreg = 1'b0; in_wd = '0; in_wdata = '0;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_wreg, wb_wd, wb_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL arst wb/busy: got %0b/%0d/%h/%0b, want 0", wb_wreg, wb_wd, wb_wdata, busy);
    end
    checks++;
    if (fwd_hit !== '0 || fwd_data !== '0) begin
      errors++;
      $display("FAIL arst fwd: got hit=%b data=%h, want 0", fwd_hit, fwd_data);
    end
    #2;
    rst = 1'b1;
    tick();
    sb_init();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_priority();
    test_r0();
    test_stall();
    test_flush();
    test_depth1();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
